// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with a two-stage output pipeline.
//   Counts pixels (h_cnt) and lines (v_cnt), hands the visible coordinate to a
//   pattern generator, and realigns sync, blank and frame-start with the
//   returned colour, which arrives one clock after its coordinate.
// Ports:
//   iVGA_CLK                 pixel clock (single clock domain)
//   iRST                     asynchronous active-high reset
//   iRed/iGreen/iBlue [9:0]  colour from pattern generator
//   oVGA_X/oVGA_Y    [9:0]  current coordinate, 0 outside the visible area
//   oREQUEST                 coordinate addresses a visible pixel (stage 0)
//   oVGA_R/G/B       [9:0]  colour to DAC (stage 2)
//   oVGA_HS/oVGA_VS          active-low sync (stage 2)
//   oVGA_BLANK_N             high in visible region (stage 2)
//   oFRAME_START             one-clock pulse for pixel (0,0) (stage 2)
//   oFRAME_CNT       [7:0]  frames seen, wraps at 255 (only with VGA_FRAME_CNT_EN)
// Optional feature macro: VGA_FRAME_CNT_EN adds the oFRAME_CNT frame counter.
module vga_timing_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33
) (
   input  logic       iVGA_CLK,
   input  logic       iRST,
   input  logic [9:0] iRed,
   input  logic [9:0] iGreen,
   input  logic [9:0] iBlue,
   output logic [9:0] oVGA_X,
   output logic [9:0] oVGA_Y,
   output logic       oREQUEST,
   output logic [9:0] oVGA_R,
   output logic [9:0] oVGA_G,
   output logic [9:0] oVGA_B,
   output logic       oVGA_HS,
   output logic       oVGA_VS,
   output logic       oVGA_BLANK_N,
`ifdef VGA_FRAME_CNT_EN
   output logic       oFRAME_START,
   output logic [7:0] oFRAME_CNT
`else
   output logic       oFRAME_START
`endif
);

   localparam int unsigned CW      = 10;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS_END  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_VIS_END  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [CW-1:0] r_h_cnt;
   logic [CW-1:0] r_v_cnt;
   logic          w_vis;
   logic          w_hs_raw;
   logic          w_vs_raw;
   logic          w_fs_raw;
   logic          r_hs1;
   logic          r_vs1;
   logic          r_req1;
   logic          r_fs1;

   // Raster counters: v_cnt advances (and wraps) on the h_cnt wrap edge.
   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         if (r_v_cnt == V_LAST) r_v_cnt <= '0;
         else                   r_v_cnt <= r_v_cnt + CW'(1);
      end else begin
         r_h_cnt <= r_h_cnt + CW'(1);
      end
   end

   // Stage 0 decode straight from the counters.
   always_comb begin
      w_vis    = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
      w_hs_raw = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
      w_vs_raw = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
      w_fs_raw = (r_h_cnt == '0) && (r_v_cnt == '0);
   end

   // Counters sit at (0,0) in reset, so the request is masked by reset itself
   // to keep the pattern generator idle until counting starts.
   assign oREQUEST = w_vis & ~iRST;
   assign oVGA_X   = oREQUEST ? r_h_cnt : '0;
   assign oVGA_Y   = oREQUEST ? r_v_cnt : '0;

   // Stage 1: waits alongside the pattern generator's colour register.
   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         r_hs1  <= 1'b1;
         r_vs1  <= 1'b1;
         r_req1 <= 1'b0;
         r_fs1  <= 1'b0;
      end else begin
         r_hs1  <= w_hs_raw;
         r_vs1  <= w_vs_raw;
         r_req1 <= oREQUEST;
         r_fs1  <= w_fs_raw;
      end
   end

   // Stage 2: colour gated by the delayed request, controls aligned with it.
   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         oVGA_R       <= '0;
         oVGA_G       <= '0;
         oVGA_B       <= '0;
         oVGA_HS      <= 1'b1;
         oVGA_VS      <= 1'b1;
         oVGA_BLANK_N <= 1'b0;
         oFRAME_START <= 1'b0;
      end else begin
         oVGA_R       <= r_req1 ? iRed   : '0;
         oVGA_G       <= r_req1 ? iGreen : '0;
         oVGA_B       <= r_req1 ? iBlue  : '0;
         oVGA_HS      <= r_hs1;
         oVGA_VS      <= r_vs1;
         oVGA_BLANK_N <= r_req1;
         oFRAME_START <= r_fs1;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] r_frame_cnt;

   // Counts on the edge that raises oFRAME_START; wraps naturally at 255.
   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST)       r_frame_cnt <= '0;
      else if (r_fs1) r_frame_cnt <= r_frame_cnt + 8'(1);
   end

   assign oFRAME_CNT = r_frame_cnt;
`endif

endmodule
